axil_cmd_initiator: RTL and testbench



---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_watchdog.sv | 42 ++++
 rtl/axil_cmd_initiator.sv | 207 ++++++++++++++++++++
 tb/tb_axil_cmd_initiator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// axil_pkg
// Shared AXI4-Lite definitions for the command initiator: response codes,
// default protection bits, the initiator state encoding and a state helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } init_state_t;

    // States in which the initiator is waiting on the AXI target.
    function automatic logic is_bus_wait(input init_state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
               (s == ST_RD_REQ) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog
// Counts cycles spent in a bus-wait state and flags expiry on the TIMEOUT-th
// consecutive cycle. TIMEOUT = 0 disables the watchdog entirely.
// Ports:
//   i_clk     clock (rising edge)
//   i_rst     synchronous active-high reset
//   i_clear   clear the count (state transition)
//   i_run     count this cycle (bus-wait state)
//   o_expired high in the TIMEOUT-th cycle of an uninterrupted wait
module axil_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    // The count never needs to exceed TIMEOUT-1.
    localparam int              CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic            EN    = (TIMEOUT != 0);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the number of completed cycles in this state, so the
    // TIMEOUT-th cycle is the one where r_cnt == TIMEOUT-1.
    assign o_expired = EN && i_run && w_at_limit;

endmodule

// File: rtl/axil_cmd_initiator.sv
// axil_cmd_initiator
// AXI4-Lite initiator: turns single-beat local commands into AXI-Lite write or
// read transactions, one outstanding at a time. A watchdog turns a hung target
// into a SLVERR response flagged with rsp_timeout and a sticky bus_fault.
// Ports:
//   axi_aclk / axi_areset        clock, synchronous active-high reset
//   cmd_*                        command handshake and payload (in)
//   rsp_*                        response handshake and payload (out)
//   bus_fault                    sticky watchdog-abort flag
//   axil_aw* / w* / b* / ar* / r* AXI4-Lite initiator channels
module axil_cmd_initiator
    import axil_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        bus_fault,
    output logic        axil_awvalid,
    output logic [31:0] axil_awaddr,
    output logic [2:0]  axil_awprot,
    input  logic        axil_awready,
    output logic        axil_wvalid,
    output logic [31:0] axil_wdata,
    output logic [3:0]  axil_wstrb,
    input  logic        axil_wready,
    input  logic        axil_bvalid,
    input  logic [1:0]  axil_bresp,
    output logic        axil_bready,
    output logic        axil_arvalid,
    output logic [31:0] axil_araddr,
    output logic [2:0]  axil_arprot,
    input  logic        axil_arready,
    input  logic        axil_rvalid,
    input  logic [31:0] axil_rdata,
    input  logic [1:0]  axil_rresp,
    output logic        axil_rready
);

    init_state_t r_state, w_state_next;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_rsp_timeout;
    logic        r_bus_fault;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_aw_done_nxt, w_w_done_nxt;
    logic w_expired, w_abort, w_accept;

    // Valids/readies decode straight from flops, so no input-to-output path.
    assign cmd_ready    = (r_state == ST_IDLE);
    assign axil_awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
    assign axil_wvalid  = (r_state == ST_WR_REQ) && !r_w_done;
    assign axil_bready  = (r_state == ST_WR_RESP);
    assign axil_arvalid = (r_state == ST_RD_REQ);
    assign axil_rready  = (r_state == ST_RD_DATA);
    assign rsp_valid    = (r_state == ST_RSP);

    assign axil_awaddr  = r_addr;
    assign axil_araddr  = r_addr;
    assign axil_wdata   = r_wdata;
    assign axil_wstrb   = r_wstrb;
    assign axil_awprot  = PROT_DEFAULT;
    assign axil_arprot  = PROT_DEFAULT;

    assign rsp_write    = r_write;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_resp     = r_rsp_resp;
    assign rsp_timeout  = r_rsp_timeout;
    assign bus_fault    = r_bus_fault;

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_aw_hs       = axil_awvalid && axil_awready;
    assign w_w_hs        = axil_wvalid && axil_wready;
    assign w_b_hs        = axil_bvalid && axil_bready;
    assign w_ar_hs       = axil_arvalid && axil_arready;
    assign w_r_hs        = axil_rvalid && axil_rready;
    assign w_aw_done_nxt = r_aw_done || w_aw_hs;
    assign w_w_done_nxt  = r_w_done || w_w_hs;

    axil_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk     (axi_aclk),
        .i_rst     (axi_areset),
        .i_clear   (w_state_next != r_state),
        .i_run     (is_bus_wait(r_state)),
        .o_expired (w_expired)
    );

    // Next-state logic: a completing handshake is always checked before the
    // watchdog, so a handshake in the expiry cycle wins.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_next = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_next = ST_WR_RESP;
                end else if (w_expired) begin
                    w_state_next = ST_RSP;
                    w_abort      = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_state_next = ST_RSP;
                end else if (w_expired) begin
                    w_state_next = ST_RSP;
                    w_abort      = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (w_ar_hs) begin
                    w_state_next = ST_RD_DATA;
                end else if (w_expired) begin
                    w_state_next = ST_RSP;
                    w_abort      = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    w_state_next = ST_RSP;
                end else if (w_expired) begin
                    w_state_next = ST_RSP;
                    w_abort      = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) r_state <= ST_IDLE;
        else            r_state <= w_state_next;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_bus_fault   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write   <= cmd_write;
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == ST_WR_REQ) begin
                r_aw_done <= w_aw_done_nxt;
                r_w_done  <= w_w_done_nxt;
            end
            if (w_b_hs) begin
                r_rsp_resp    <= axil_bresp;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b0;
            end
            if (w_r_hs) begin
                r_rsp_resp    <= axil_rresp;
                r_rsp_rdata   <= axil_rdata;
                r_rsp_timeout <= 1'b0;
            end
            if (w_abort) begin
                r_rsp_resp    <= RESP_SLVERR;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b1;
                r_bus_fault   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_cmd_initiator.sv
// tb_axil_cmd_initiator
// Directed bench: a configurable AXI-Lite target model (per-channel wait
// counts, stall flags, programmable responses) driven on the falling edge,
// with all DUT outputs sampled on the falling edge. Expected values are
// hand-computed cycle offsets from command acceptance.
module tb_axil_cmd_initiator;

    logic        clk = 1'b0;
    logic        axi_areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, bus_fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        axil_awvalid, axil_awready, axil_wvalid, axil_wready;
    logic [31:0] axil_awaddr, axil_wdata, axil_araddr, axil_rdata;
    logic [2:0]  axil_awprot, axil_arprot;
    logic [3:0]  axil_wstrb;
    logic        axil_bvalid, axil_bready, axil_arvalid, axil_arready;
    logic        axil_rvalid, axil_rready;
    logic [1:0]  axil_bresp, axil_rresp;

    always #5 clk = ~clk;

    axil_cmd_initiator #(.TIMEOUT(16)) dut (
        .axi_aclk(clk), .axi_areset(axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .bus_fault(bus_fault),
        .axil_awvalid(axil_awvalid), .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
        .axil_awready(axil_awready),
        .axil_wvalid(axil_wvalid), .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
        .axil_wready(axil_wready),
        .axil_bvalid(axil_bvalid), .axil_bresp(axil_bresp), .axil_bready(axil_bready),
        .axil_arvalid(axil_arvalid), .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
        .axil_arready(axil_arready),
        .axil_rvalid(axil_rvalid), .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
        .axil_rready(axil_rready)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Target model configuration and observations.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          ar_never = 0, b_never = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, arv_cycles = 0;
    int          aw_cyc = 0, w_cyc = 0;
    logic [31:0] aw_addr_s = '0, w_data_s = '0, ar_addr_s = '0;
    logic [3:0]  w_strb_s = '0;
    logic [2:0]  prot_or = '0;

    initial begin
        axil_awready = 0; axil_wready = 0; axil_bvalid = 0; axil_bresp = 0;
        axil_arready = 0; axil_rvalid = 0; axil_rdata = 0; axil_rresp = 0;
    end

    // Readies/valids are decided on the falling edge, so a handshake recorded
    // here completes on the following rising edge of cycle 'cyc'.
    always @(negedge clk) begin
        if (axil_awvalid) begin
            if (aw_wait >= aw_dly) begin
                axil_awready = 1; n_aw++; aw_cyc = cyc; aw_addr_s = axil_awaddr;
                prot_or |= axil_awprot; aw_wait = 0;
            end else begin
                axil_awready = 0; aw_wait++;
            end
        end else begin
            axil_awready = 0; aw_wait = 0;
        end
        if (axil_wvalid) begin
            if (w_wait >= w_dly) begin
                axil_wready = 1; n_w++; w_cyc = cyc; w_data_s = axil_wdata;
                w_strb_s = axil_wstrb; w_wait = 0;
            end else begin
                axil_wready = 0; w_wait++;
            end
        end else begin
            axil_wready = 0; w_wait = 0;
        end
        if (axil_bready && !b_never && b_wait >= b_dly) begin
            axil_bvalid = 1; axil_bresp = b_resp_cfg; n_b++; b_wait = 0;
        end else begin
            if (axil_bready) b_wait++; else b_wait = 0;
            axil_bvalid = 0; axil_bresp = 0;
        end
        if (axil_arvalid) begin
            arv_cycles++;
            if (!ar_never && ar_wait >= ar_dly) begin
                axil_arready = 1; n_ar++; ar_addr_s = axil_araddr;
                prot_or |= axil_arprot; ar_wait = 0;
            end else begin
                axil_arready = 0; ar_wait++;
            end
        end else begin
            axil_arready = 0; ar_wait = 0;
        end
        if (axil_rready && r_wait >= r_dly) begin
            axil_rvalid = 1; axil_rdata = r_data_cfg; axil_rresp = r_resp_cfg;
            n_r++; r_wait = 0;
        end else begin
            if (axil_rready) r_wait++; else r_wait = 0;
            axil_rvalid = 0; axil_rdata = 0; axil_rresp = 0;
        end
    end

    task automatic clear_stats();
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; arv_cycles = 0;
        aw_cyc = -1; w_cyc = -1;
    endtask

    // Present one command on a falling edge; t0 is its acceptance cycle.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string tag);
        @(negedge clk);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    endtask

    // Returns cycles from acceptance to first rsp_valid (-1 if never) and
    // whether cmd_ready was ever seen high while waiting.
    task automatic wait_rsp(output int at, output bit cr_hi);
        at = -1; cr_hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                at = cyc - t0;
                break;
            end
            if (cmd_ready) cr_hi = 1;
            @(negedge clk);
        end
        if (at < 0) check("rsp_wait_bound", 0, 1);
    endtask

    // Hold rsp_ready low for 'hold' cycles, then accept. 'unstable' flags any
    // change of rsp_rdata, loss of rsp_valid or cmd_ready rising early.
    task automatic accept_rsp(input int hold, output bit unstable);
        logic [31:0] held;
        held = rsp_rdata; unstable = 0;
        for (int i = 0; i < hold; i++) begin
            if (rsp_rdata !== held || !rsp_valid || cmd_ready) unstable = 1;
            @(negedge clk);
        end
        if (rsp_rdata !== held || !rsp_valid || cmd_ready) unstable = 1;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    int at;
    bit cr_hi, unstable, seen;

    initial begin
        #200000;
        $display("FAIL global_time_limit: got=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        axi_areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_bus_fault", bus_fault, 0);
        check("rst_valids", {axil_awvalid, axil_wvalid, axil_bready, axil_arvalid,
                             axil_rready, rsp_valid}, 0);
        check("rst_rsp", {rsp_resp, rsp_timeout, rsp_write}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", axil_awaddr, 0);
        axi_areset = 0;
        @(negedge clk);

        // 1: zero-wait write
        clear_stats(); prot_or = 0;
        send_cmd(1, 32'h7203_0000, 32'hDEAD_BEEF, 4'hF, "t1");
        wait_rsp(at, cr_hi);
        check("t1_aw_cycle", aw_cyc - t0, 1);
        check("t1_w_cycle", w_cyc - t0, 1);
        check("t1_rsp_cycle", at, 3);
        check("t1_awaddr", aw_addr_s, 32'h7203_0000);
        check("t1_wdata", w_data_s, 32'hDEAD_BEEF);
        check("t1_wstrb", w_strb_s, 4'hF);
        check("t1_rsp_resp", rsp_resp, 2'b00);
        check("t1_rsp_write", rsp_write, 1);
        check("t1_rsp_rdata", rsp_rdata, 0);
        check("t1_rsp_timeout", rsp_timeout, 0);
        accept_rsp(0, unstable);

        // 2: W accepted 3 cycles before AW, SLVERR on B
        clear_stats(); aw_dly = 3; b_resp_cfg = 2'b10;
        send_cmd(1, 32'h0000_0044, 32'h0BAD_F00D, 4'h5, "t2");
        wait_rsp(at, cr_hi);
        check("t2_n_aw", n_aw, 1);
        check("t2_n_w", n_w, 1);
        check("t2_w_cycle", w_cyc - t0, 1);
        check("t2_aw_cycle", aw_cyc - t0, 4);
        check("t2_rsp_cycle", at, 6);
        check("t2_rsp_resp", rsp_resp, 2'b10);
        check("t2_rsp_timeout", rsp_timeout, 0);
        check("t2_bus_fault", bus_fault, 0);
        check("t2_wstrb", w_strb_s, 4'h5);
        accept_rsp(0, unstable);
        aw_dly = 0; b_resp_cfg = 2'b00;

        // 3: read with 5 wait cycles on R, rsp_ready held low for 4 cycles
        clear_stats(); r_dly = 5; r_data_cfg = 32'h1234_5678;
        send_cmd(0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, "t3");
        wait_rsp(at, cr_hi);
        check("t3_rsp_cycle", at, 8);
        check("t3_araddr", ar_addr_s, 32'h0000_0010);
        check("t3_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("t3_rsp_write", rsp_write, 0);
        check("t3_rsp_resp", rsp_resp, 2'b00);
        accept_rsp(4, unstable);
        check("t3_held_stable", unstable, 0);
        check("t3_cmd_ready_low", cr_hi, 0);
        check("t3_cmd_ready_after", cmd_ready, 1);
        r_dly = 0; r_data_cfg = 0;

        // 4: target never asserts arready -> watchdog abort after 16 cycles
        clear_stats(); ar_never = 1;
        send_cmd(0, 32'h0000_0020, 32'h0, 4'h0, "t4");
        wait_rsp(at, cr_hi);
        check("t4_arvalid_cycles", arv_cycles, 16);
        check("t4_rsp_cycle", at, 17);
        check("t4_arvalid_dropped", axil_arvalid, 0);
        check("t4_rsp_resp", rsp_resp, 2'b10);
        check("t4_rsp_timeout", rsp_timeout, 1);
        check("t4_rsp_rdata", rsp_rdata, 0);
        check("t4_bus_fault", bus_fault, 1);
        accept_rsp(0, unstable);
        ar_never = 0;

        // 4b: next command still completes normally; bus_fault stays sticky
        clear_stats();
        send_cmd(1, 32'h0000_0008, 32'hCAFE_0001, 4'hC, "t4b");
        wait_rsp(at, cr_hi);
        check("t4b_rsp_cycle", at, 3);
        check("t4b_rsp_resp", rsp_resp, 2'b00);
        check("t4b_rsp_timeout", rsp_timeout, 0);
        check("t4b_bus_fault", bus_fault, 1);
        check("t4b_prot", prot_or, 0);
        accept_rsp(0, unstable);

        // 5: reset pulsed while waiting in WR_RESP
        clear_stats(); b_never = 1;
        send_cmd(1, 32'h0000_0100, 32'hA5A5_A5A5, 4'h3, "t5");
        @(negedge clk);
        check("t5_in_wr_resp", axil_bready, 1);
        axi_areset = 1;
        @(negedge clk);
        axi_areset = 0;
        check("t5_valids", {axil_awvalid, axil_wvalid, axil_bready, axil_arvalid,
                            axil_rready, rsp_valid}, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_bus_fault", bus_fault, 0);
        b_never = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("t5_no_rsp", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
